// File: rtl/spin_sampler.sv
// Run controller and spin readout stage behind the Ising core: times the anneal and majority-votes the synchronised spins.
// Optional SPIN_SAMPLER_FLIPCOUNT_EN adds a saturating spin-flip counter (FLIPS, offset 0x10).
module spin_sampler #(
    parameter int unsigned N              = 8,
    parameter logic [7:0]  CTRL_ADDR_MASK = 8'h02,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NUM_SAMPLES    = 7
) (
    input  logic          clk,
    input  logic          axi_rst,
    input  logic          wready,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wdata,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rdata,
    input  logic [N-1:0]  external_spin,
    output logic          ising_rstn,
    output logic          busy,
    output logic          done
);

    localparam int unsigned VOTE_W = 8;
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_RUN    = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [VOTE_W-1:0] LAST_SAMPLE = VOTE_W'(NUM_SAMPLES - 1);
    localparam logic [VOTE_W-1:0] MAJORITY    = VOTE_W'(NUM_SAMPLES / 2);

    typedef enum logic [7:0] {
        ST_IDLE   = 8'h00,
        ST_RUN    = 8'h01,
        ST_SAMPLE = 8'h02,
        ST_DONE   = 8'h03
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]                   run_cycles;
    logic [31:0]                   cnt;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  spin_s;
    logic [N-1:0]                  result;
    logic [N-1:0][VOTE_W-1:0]      vote_q;
    logic [N-1:0][VOTE_W-1:0]      vote_sum;
    logic [VOTE_W-1:0]             sample_idx;
    logic                          wr_hit;
    logic                          start_wr;
    logic                          abort_wr;
    logic                          run_wr;
    logic                          start_go;
    logic                          sample_enter;
    logic                          result_load;
    logic                          unused;

    // Register bus write decode
    assign wr_hit   = wready && (wr_addr[31:24] == CTRL_ADDR_MASK);
    assign start_wr = wr_hit && (wr_addr[7:0] == OFF_CTRL) && wdata[0];
    assign abort_wr = wr_hit && (wr_addr[7:0] == OFF_CTRL) && wdata[1];
    assign run_wr   = wr_hit && (wr_addr[7:0] == OFF_RUN);
    assign unused   = ^{wr_addr[23:8], rd_addr[23:8]};

    // Multi-flop synchroniser on the asynchronous spin bus
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], external_spin};
        end
    end

    assign spin_s = sync_q[SYNC_STAGES-1];

    // State register and registered run outputs
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state      <= ST_IDLE;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            ising_rstn <= (state_next == ST_RUN) || (state_next == ST_SAMPLE);
            busy       <= (state_next == ST_RUN) || (state_next == ST_SAMPLE);
            done       <= (state_next == ST_DONE);
        end
    end

    // Next-state logic; ABORT always takes priority over START
    always_comb begin
        state_next   = state;
        start_go     = 1'b0;
        sample_enter = 1'b0;
        result_load  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (abort_wr) begin
                    state_next = ST_IDLE;
                end else if (start_wr) begin
                    state_next = ST_RUN;
                    start_go   = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort_wr) begin
                    state_next = ST_IDLE;
                end else if (cnt == 32'd0) begin
                    state_next   = ST_SAMPLE;
                    sample_enter = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (abort_wr) begin
                    state_next = ST_IDLE;
                end else if (sample_idx == LAST_SAMPLE) begin
                    state_next  = ST_DONE;
                    result_load = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // RUN_CYCLES register and anneal window counter
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            run_cycles <= 32'd0;
            cnt        <= 32'd0;
        end else begin
            if (run_wr) begin
                run_cycles <= wdata;
            end
            if (start_go) begin
                cnt <= run_cycles;
            end else if ((state == ST_RUN) && (cnt != 32'd0)) begin
                cnt <= cnt - 32'd1;
            end
        end
    end

    always_comb begin
        vote_sum = '0;
        for (int i = 0; i < int'(N); i++) begin
            vote_sum[i] = vote_q[i] + VOTE_W'(spin_s[i]);
        end
    end

    // Per-bit vote counters and result latch
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            sample_idx <= '0;
            vote_q     <= '0;
            result     <= '0;
        end else begin
            if (sample_enter) begin
                sample_idx <= '0;
                vote_q     <= '0;
            end else if (state == ST_SAMPLE) begin
                sample_idx <= sample_idx + VOTE_W'(1);
                vote_q     <= vote_sum;
            end
            if (result_load) begin
                for (int i = 0; i < int'(N); i++) begin
                    result[i] <= (vote_sum[i] > MAJORITY);
                end
            end
        end
    end

`ifdef SPIN_SAMPLER_FLIPCOUNT_EN
    localparam logic [7:0] OFF_FLIPS = 8'h10;

    logic [N-1:0] spin_s_q;
    logic [31:0]  flips;
    logic [31:0]  flip_pop;
    logic [32:0]  flip_sum;

    always_comb begin
        flip_pop = 32'd0;
        for (int i = 0; i < int'(N); i++) begin
            flip_pop = flip_pop + 32'(spin_s[i] ^ spin_s_q[i]);
        end
        flip_sum = {1'b0, flips} + {1'b0, flip_pop};
    end

    // Saturating count of spin toggles seen during RUN
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            spin_s_q <= '0;
            flips    <= 32'd0;
        end else begin
            spin_s_q <= spin_s;
            if (start_go) begin
                flips <= 32'd0;
            end else if (state == ST_RUN) begin
                flips <= flip_sum[32] ? 32'hFFFF_FFFF : flip_sum[31:0];
            end
        end
    end
`endif

    // Combinational register readback
    always_comb begin
        rdata = 32'd0;
        if (rd_addr[31:24] == CTRL_ADDR_MASK) begin
            case (rd_addr[7:0])
                OFF_RUN:    rdata = run_cycles;
                OFF_STATUS: rdata = {16'd0, 8'(state), 6'd0, done, busy};
                OFF_RESULT: rdata = 32'(result);
`ifdef SPIN_SAMPLER_FLIPCOUNT_EN
                OFF_FLIPS:  rdata = flips;
`endif
                default:    rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_spin_sampler.sv
// Randomised self-checking bench for spin_sampler against a schedule-level run/vote model.
module tb_spin_sampler;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int NS = 7;

    logic        clk = 1'b0;
    logic        axi_rst;
    logic        wready;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] rdata;
    logic [N-1:0] external_spin;
    logic        ising_rstn;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    spin_sampler #(
        .N(N),
        .CTRL_ADDR_MASK(8'h02),
        .SYNC_STAGES(SS),
        .NUM_SAMPLES(NS)
    ) dut (
        .clk(clk),
        .axi_rst(axi_rst),
        .wready(wready),
        .wr_addr(wr_addr),
        .wdata(wdata),
        .rd_addr(rd_addr),
        .rdata(rdata),
        .external_spin(external_spin),
        .ising_rstn(ising_rstn),
        .busy(busy),
        .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0]  hist[$];
    logic [31:0] rc_reg;
    logic [7:0]  exp_result;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    // Record this cycle's spin drive, then move to just after the next rising edge
    task automatic cycle_end();
        hist.push_back(external_spin);
        @(posedge clk);
        #1;
        wready = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [7:0] sel);
        wready  = 1'b1;
        wr_addr = {sel, 16'h0, off};
        wdata   = d;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        rd_addr = {8'h02, 16'h0, off};
        #1;
        d = rdata;
    endtask

    // Spin value the DUT votes on in cycle j: the bus as driven SS cycles earlier
    function automatic logic [7:0] spin_at(input int j);
        if (j < SS) return 8'h00;
        return hist[j-SS];
    endfunction

    function automatic logic [7:0] majority_of(input int first);
        logic [7:0] r;
        logic [7:0] v;
        int ones;
        r = 8'h00;
        for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int k = 0; k < NS; k++) begin
                v = spin_at(first + k);
                ones += int'(v[b]);
            end
            r[b] = (ones > NS / 2);
        end
        return r;
    endfunction

    // mode 0 random, 1 constant, 2 bit0 4/7 + bit1 3/7 in the sample window, 3 constant upper with bit0 toggling
    function automatic logic [7:0] drive_val(input int mode, input logic [7:0] cval, input int c,
                                             input int w, input int rc);
        logic [7:0] v;
        int k;
        v = 8'h00;
        case (mode)
            0: v = 8'($urandom);
            1: v = cval;
            2: begin
                k = c + SS - (w + 2 + rc);
                if (k >= 0 && k < NS) begin
                    v[0] = (k < 4);
                    v[1] = (k >= 4);
                end
            end
            default: v = {cval[7:1], c[0]};
        endcase
        return v;
    endfunction

    task automatic do_run(input int rc, input int mode, input logic [7:0] cval,
                          input int abort_at, input int bstart_at, input int rcw_at);
        int w, last, aborted_c, high;
        logic [31:0] d;
        logic [31:0] ctrl;
        logic [7:0]  prev;
        logic        e_on, e_done;
        prev = exp_result;
        w = hist.size() + 1;
        wr(8'h04, 32'(rc), 8'h02);
        rc_reg = 32'(rc);
        external_spin = drive_val(mode, cval, hist.size(), w, rc);
        cycle_end();
        wr(8'h00, 32'h1, 8'h02);
        external_spin = drive_val(mode, cval, hist.size(), w, rc);
        cycle_end();
        last = w + 1 + rc + NS;
        aborted_c = -1;
        high = 0;
        for (int c = w + 1; c <= last + 1; c++) begin
            if (aborted_c >= 0) begin
                e_on = 1'b0;
                e_done = 1'b0;
            end else begin
                e_on = (c <= last);
                e_done = (c > last);
            end
            check("ising_rstn", 32'(ising_rstn), 32'(e_on));
            check("busy", 32'(busy), 32'(e_on));
            check("done", 32'(done), 32'(e_done));
            if (ising_rstn) high++;
            if (c == w + 1) begin
                rd(8'h0C, d);
                check("result_while_busy", d, 32'(prev));
                rd(8'h08, d);
                check("status_busy", 32'(d[1:0]), 32'h1);
            end
            if (aborted_c >= 0 || c == last + 1) break;
            external_spin = drive_val(mode, cval, c, w, rc);
            ctrl = 32'h0;
            if (c - w == bstart_at) ctrl[0] = 1'b1;
            if (c - w == abort_at)  ctrl[1] = 1'b1;
            if (ctrl != 32'h0) begin
                wr(8'h00, ctrl, 8'h02);
                if (ctrl[1]) aborted_c = c;
            end else if (c - w == rcw_at) begin
                d = 32'($urandom_range(0, 50));
                wr(8'h04, d, 8'h02);
                rc_reg = d;
            end
            cycle_end();
        end
        if (aborted_c < 0) begin
            exp_result = majority_of(w + 2 + rc);
            check("ising_high_cycles", 32'(high), 32'(rc + 1 + NS));
        end
        rd(8'h0C, d);
        check("result", d, 32'(exp_result));
        rd(8'h08, d);
        check("status_end", 32'(d[1:0]), (aborted_c < 0) ? 32'h2 : 32'h0);
        rd(8'h04, d);
        check("run_cycles_rb", d, rc_reg);
        cycle_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int rc, ab, bs, rw;
        axi_rst = 1'b1;
        wready = 1'b0;
        wr_addr = 32'h0;
        wdata = 32'h0;
        rd_addr = 32'h0;
        external_spin = '0;
        rc_reg = 32'h0;
        exp_result = 8'h00;

        // Reset state
        repeat (3) cycle_end();
        check("rst_ising_rstn", 32'(ising_rstn), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rd(8'h0C, d); check("rst_result", d, 32'h0);
        rd(8'h08, d); check("rst_status", d, 32'h0);
        rd(8'h04, d); check("rst_run_cycles", d, 32'h0);
        axi_rst = 1'b0;
        repeat (3) cycle_end();

        // Basic run, abort with old result kept, then majority window
        do_run(10, 1, 8'hA5, -1, -1, -1);
        rd(8'h0C, d); check("basic_result", d, 32'hA5);
        do_run(10, 0, 8'h00, 3, -1, -1);
        rd(8'h0C, d); check("abort_keeps_result", d, 32'hA5);
        do_run(3, 2, 8'h00, -1, -1, -1);
        rd(8'h0C, d); check("majority_bits", 32'(d[1:0]), 32'h1);

        // RUN_CYCLES = 0, START while busy, RUN_CYCLES write while busy
        do_run(0, 0, 8'h00, -1, -1, -1);
        do_run(5, 0, 8'h00, -1, 4, 7);

        // ABORT in DONE, START+ABORT in IDLE and in DONE
        wr(8'h00, 32'h2, 8'h02); cycle_end();
        check("abort_in_done_done", 32'(done), 32'h0);
        check("abort_in_done_busy", 32'(busy), 32'h0);
        wr(8'h00, 32'h3, 8'h02); cycle_end();
        check("start_abort_idle_busy", 32'(busy), 32'h0);
        check("start_abort_idle_rstn", 32'(ising_rstn), 32'h0);
        cycle_end();
        do_run(1, 0, 8'h00, -1, -1, -1);
        wr(8'h00, 32'h3, 8'h02); cycle_end();
        check("start_abort_done_done", 32'(done), 32'h0);
        check("start_abort_done_busy", 32'(busy), 32'h0);
        rd(8'h0C, d); check("start_abort_done_result", d, 32'(exp_result));

        // Non-matching block select and unmapped offsets
        wr(8'h00, 32'h1, 8'h03); cycle_end();
        check("foreign_start_busy", 32'(busy), 32'h0);
        rd_addr = 32'h0300_000C; #1;
        check("foreign_read", rdata, 32'h0);
        rd(8'h14, d); check("unmapped_read", d, 32'h0);
        cycle_end();

        // Randomised runs with occasional abort, busy START and RUN_CYCLES rewrite
        for (int i = 0; i < 12; i++) begin
            rc = int'($urandom_range(0, 12));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rc + 1 + NS)) : -1;
            bs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, rc + NS)) : -1;
            rw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, rc + NS)) : -1;
            do_run(rc, 0, 8'h00, ab, bs, rw);
        end

        // Flip counter: bit0 toggles every cycle, upper bits constant, 20 RUN cycles
        repeat (4) begin
            external_spin = drive_val(3, 8'h5A, hist.size(), 0, 0);
            cycle_end();
        end
        do_run(19, 3, 8'h5A, -1, -1, -1);
        rd(8'h10, d);
`ifdef SPIN_SAMPLER_FLIPCOUNT_EN
        check("flips_range", 32'(d >= 32'd19 && d <= 32'd21), 32'h1);
`else
        check("flips_absent", d, 32'h0);
`endif

        // Asynchronous reset in the middle of SAMPLE
        wr(8'h04, 32'h2, 8'h02); cycle_end();
        wr(8'h00, 32'h1, 8'h02); cycle_end();
        repeat (3) cycle_end();
        check("pre_reset_busy", 32'(busy), 32'h1);
        #2;
        axi_rst = 1'b1;
        #1;
        check("async_rst_ising_rstn", 32'(ising_rstn), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        rd(8'h0C, d); check("async_rst_result", d, 32'h0);
        rd(8'h04, d); check("async_rst_run_cycles", d, 32'h0);
        rd(8'h08, d); check("async_rst_status", d, 32'h0);
        cycle_end();
        axi_rst = 1'b0;
        exp_result = 8'h00;
        rc_reg = 32'h0;
        repeat (4) cycle_end();
        do_run(0, 0, 8'h00, -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
